// File: rtl/bcd_counter_n.sv
// Cascaded BCD up/down counter with validated parallel load and wrap/saturate at the terminal value.
// Q and ERR update one CLK edge after sampling; CO is combinational; no backpressure, ENABLE low holds.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                ENABLE,
  input  logic                LOAD,
  input  logic                UP,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic                CO,
  output logic                ERR
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] q_nxt;
  logic         d_ok;
  logic         all9;
  logic         all0;
  logic         term;
  logic         step;
  logic [3:0]   dig;

  always_comb begin
    d_ok = 1'b1;
    all9 = 1'b1;
    all0 = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (D[4*k +: 4] > 4'd9) d_ok = 1'b0;
      if (Q[4*k +: 4] != 4'd9) all9 = 1'b0;
      if (Q[4*k +: 4] != 4'd0) all0 = 1'b0;
    end
  end

  assign term = UP ? all9 : all0;
  assign CO   = ENABLE & ~LOAD & term;

  // A digit steps only while every lower digit sits at its roll-over value.
  always_comb begin
    q_nxt = Q;
    step  = 1'b1;
    dig   = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = Q[4*k +: 4];
      if (step) begin
        if (UP) q_nxt[4*k +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        else    q_nxt[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
      step = step & (UP ? (dig == 4'd9) : (dig == 4'd0));
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      Q   <= '0;
      ERR <= 1'b0;
    end else begin
      ERR <= 1'b0;
      if (ENABLE) begin
        if (LOAD) begin
          if (d_ok) Q   <= D;
          else      ERR <= 1'b1;
        end else if (!(WRAP == 0 && term)) begin
          Q <= q_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench: wrapping and saturating 4-digit counters share stimulus; two 2-digit counters are chained via CO.
module tb_bcd_counter_n;

  logic        CLK;
  logic        CLR;
  logic        ENABLE, LOAD, UP;
  logic [15:0] D;
  logic [15:0] q_a, q_b;
  logic        co_a, co_b, err_a, err_b;
  logic        en_c;
  logic [7:0]  q_c0, q_c1;
  logic        co_c0, co_c1, err_c0, err_c1;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] q;
    logic        err;
  } exp_t;

  exp_t sb[$];

  bcd_counter_n #(.DIGITS(4), .WRAP(1)) u_a (
    .CLK(CLK), .CLR(CLR), .ENABLE(ENABLE), .LOAD(LOAD), .UP(UP), .D(D),
    .Q(q_a), .CO(co_a), .ERR(err_a)
  );

  bcd_counter_n #(.DIGITS(4), .WRAP(0)) u_b (
    .CLK(CLK), .CLR(CLR), .ENABLE(ENABLE), .LOAD(LOAD), .UP(UP), .D(D),
    .Q(q_b), .CO(co_b), .ERR(err_b)
  );

  bcd_counter_n #(.DIGITS(2), .WRAP(1)) u_c0 (
    .CLK(CLK), .CLR(CLR), .ENABLE(en_c), .LOAD(1'b0), .UP(1'b1), .D(8'h00),
    .Q(q_c0), .CO(co_c0), .ERR(err_c0)
  );

  bcd_counter_n #(.DIGITS(2), .WRAP(1)) u_c1 (
    .CLK(CLK), .CLR(CLR), .ENABLE(co_c0), .LOAD(1'b0), .UP(1'b1), .D(8'h00),
    .Q(q_c1), .CO(co_c1), .ERR(err_c1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic ld, input logic up, input logic [15:0] d);
    @(negedge CLK);
    ENABLE = en;
    LOAD   = ld;
    UP     = up;
    D      = d;
  endtask

  task automatic push(input string tag, input int sel, input logic [15:0] q, input logic err);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.q   = q;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t        e;
    logic [15:0] obs;
    logic        oe;
    @(posedge CLK);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin obs = q_a; oe = err_a; end
        1:       begin obs = q_b; oe = err_b; end
        default: begin obs = {q_c1, q_c0}; oe = err_c0 | err_c1; end
      endcase
      chk({e.tag, "_q"}, obs, e.q);
      chk({e.tag, "_err"}, oe, e.err);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  initial begin
    CLR = 1'b1; ENABLE = 1'b0; LOAD = 1'b0; UP = 1'b1; D = '0; en_c = 1'b0;
    #1 CLR = 1'b0;
    #1;
    chk("rst_qa", q_a, 16'h0000);
    chk("rst_qb", q_b, 16'h0000);
    chk("rst_err", err_a, 1'b0);
    chk("rst_co_idle", co_a, 1'b0);
    ENABLE = 1'b1; UP = 1'b0;
    #1 chk("rst_co_down", co_a, 1'b1);
    @(negedge CLK);
    CLR = 1'b1; ENABLE = 1'b0; UP = 1'b1;

    // Up-count carry and wrap
    drive(1, 1, 1, 16'h0999); push("ld0999", 0, 16'h0999, 0); tick();
    drive(1, 0, 1, 16'h0000); push("up1000", 0, 16'h1000, 0); tick();
    drive(1, 1, 1, 16'h9999); push("ld9999", 0, 16'h9999, 0); tick();
    drive(1, 0, 1, 16'h0000); #1 chk("co_up_term", co_a, 1'b1);
    push("wrap_up", 0, 16'h0000, 0); tick();

    // Down-count borrow and wrap
    drive(1, 1, 1, 16'h1000); push("ld1000", 0, 16'h1000, 0); tick();
    drive(1, 0, 0, 16'h0000); #1 chk("co_dn_nonterm", co_a, 1'b0);
    push("dn0999", 0, 16'h0999, 0); tick();
    drive(1, 1, 0, 16'h0000); push("ld0000", 0, 16'h0000, 0); tick();
    drive(1, 0, 0, 16'h0000); #1 chk("co_dn_term", co_a, 1'b1);
    push("wrap_dn", 0, 16'h9999, 0); tick();

    // Saturating instance
    drive(1, 1, 1, 16'h9999); push("sat_ld", 1, 16'h9999, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 16'h0000); #1 chk("sat_co", co_b, 1'b1);
      push("sat_hold", 1, 16'h9999, 0); tick();
    end
    drive(1, 0, 0, 16'h0000); #1 chk("sat_co_rev", co_b, 1'b0);
    push("sat_rev", 1, 16'h9998, 0); tick();
    drive(1, 1, 0, 16'h0000); push("sat_ld0", 1, 16'h0000, 0); tick();
    drive(1, 0, 0, 16'h0000); push("sat_hold0", 1, 16'h0000, 0); tick();
    drive(1, 0, 1, 16'h0000); push("sat_up0", 1, 16'h0001, 0); tick();

    // Load validation
    drive(1, 1, 1, 16'h0042); push("ld0042", 0, 16'h0042, 0); tick();
    drive(1, 1, 1, 16'h12A4); push("rej12A4", 0, 16'h0042, 1); tick();
    drive(0, 0, 1, 16'h0000); push("err_1cyc", 0, 16'h0042, 0); tick();
    drive(1, 1, 1, 16'hF000); push("rejF000", 0, 16'h0042, 1); tick();
    drive(1, 1, 1, 16'h1294); push("ld1294", 0, 16'h1294, 0); tick();

    // Enable gating and asynchronous clear
    drive(0, 1, 1, 16'h5555); #1 chk("co_disabled", co_a, 1'b0);
    push("hold_dis", 0, 16'h1294, 0); tick();
    drive(1, 0, 1, 16'h0000); push("up1295", 0, 16'h1295, 0); tick();
    drive(1, 1, 1, 16'hAAAA); push("rejAAAA", 0, 16'h1295, 1); tick();
    #2 CLR = 1'b0;
    #1;
    chk("clr_q_now", q_a, 16'h0000);
    chk("clr_err_now", err_a, 1'b0);
    drive(1, 1, 1, 16'h7777);
    @(posedge CLK); #1 chk("clr_overrides_load", q_a, 16'h0000);
    @(negedge CLK);
    CLR = 1'b1; ENABLE = 1'b1; LOAD = 1'b0; UP = 1'b1;
    push("post_clr", 0, 16'h0001, 0); tick();

    // Chained pair: one increment per edge, wraps at 9999
    chk("chain_start", {q_c1, q_c0}, 16'h0000);
    @(negedge CLK);
    ENABLE = 1'b0;
    en_c = 1'b1;
    for (int n = 1; n <= 10000; n++) begin
      push("chain", 2, to_bcd(n % 10000), 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, number of cascaded BCD digits (1..8).
REQ-002 The block SHALL have parameter WRAP, default 1: 1 = wrap at terminal value, 0 = saturate at terminal value.
REQ-003 The block SHALL have port CLK  input  1  rising-edge clock.
REQ-004 The block SHALL have port CLR  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port ENABLE  input  1  qualifies LOAD and counting.
REQ-006 The block SHALL have port LOAD  input  1  parallel load request.
REQ-007 The block SHALL have port UP  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port D  input  4*DIGITS  parallel load value, digit 0 in bits [3:0].
REQ-009 The block SHALL have port Q  output  4*DIGITS  registered count, digit 0 in bits [3:0].
REQ-010 The block SHALL have port CO  output  1  combinational terminal-count / carry-out.
REQ-011 The block SHALL have port ERR  output  1  registered one-cycle pulse flagging a rejected load.

Function
REQ-012 Q SHALL represent an unsigned decimal value 0..(10^DIGITS - 1), one BCD digit per nibble; every digit of Q SHALL always be 0..9.
REQ-013 Per-edge priority SHALL be: ENABLE low -> hold; else LOAD high -> load; else count in the UP direction.
REQ-014 Load SHALL accept D only if every nibble is 0..9; Q <= D on the same edge.
REQ-015 A load with any nibble of D > 9 SHALL leave Q unchanged and set ERR high for exactly the next cycle.
REQ-016 ERR SHALL be low in every cycle that does not follow a rejected load.
REQ-017 Count up: digit 0 SHALL increment; digit k SHALL increment only when digits 0..k-1 are all 9; each incremented digit at 9 SHALL become 0.
REQ-018 Count down: digit 0 SHALL decrement; digit k SHALL decrement only when digits 0..k-1 are all 0; each decremented digit at 0 SHALL become 9.
REQ-019 Terminal value SHALL be all digits 9 when UP = 1, all digits 0 when UP = 0.
REQ-020 With WRAP = 1, up from all-9 SHALL go to all-0 and down from all-0 SHALL go to all-9.
REQ-021 With WRAP = 0, counting at the terminal value SHALL hold Q; counting in the opposite direction from it SHALL proceed normally.
REQ-022 CO SHALL equal ENABLE AND NOT LOAD AND (Q equals the terminal value for the current UP).
REQ-023 CO SHALL be identical for both WRAP settings, so that two instances chain by driving the upper instance's ENABLE from the lower instance's CO.
REQ-024 A change of UP SHALL take effect on the next edge, with no idle cycle.
REQ-025 Latency from ENABLE/LOAD/UP sampling to Q SHALL be one clock edge; no other pipelining is permitted.

Reset
REQ-026 CLR low SHALL immediately force Q to 0 and ERR to 0, independent of CLK.
REQ-027 CLR SHALL override LOAD and ENABLE for as long as it is low.
REQ-028 On the first rising CLK edge after CLR is released, the block SHALL act normally on the inputs sampled at that edge.
REQ-029 CO SHALL follow REQ-022 during reset; it is therefore high when ENABLE = 1, LOAD = 0 and UP = 0.

Verification
REQ-030 DIGITS=4, WRAP=1: load 0x0999, ENABLE=1, UP=1 -> Q=0x1000 after one edge; then load 0x9999 -> CO=1; next edge -> Q=0x0000.
REQ-031 DIGITS=4, WRAP=1: Q=0x1000, UP=0 -> Q=0x0999; from 0x0000 -> CO=1 and next edge Q=0x9999.
REQ-032 DIGITS=4, WRAP=0: Q=0x9999, UP=1 for 3 edges -> Q stays 0x9999 and CO=1; set UP=0 -> Q=0x9998.
REQ-033 Load D=0x12A4 -> Q unchanged, ERR=1 for exactly one cycle; then load D=0x1294 -> Q=0x1294, ERR=0.
REQ-034 ENABLE=0 with LOAD=1 and D=0x5555 -> Q holds, CO=0; assert CLR mid-count between edges -> Q=0x0000 immediately, count resumes from 0x0001 (UP=1) on the first edge after release.
REQ-035 Two DIGITS=2 instances chained via CO->ENABLE, counting up from 0 -> combined value increments by one per edge through 0x0099 -> 0x0100, and wraps 0x9999 -> 0x0000.
